// File: rtl/alu_selftest_checker.sv
// Built-in self-test companion for the RISC-V ALU: drives one latched operand pair
// through all eight operations and checks each sampled result against a golden model.
module alu_selftest_checker #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] rs1,
    output logic [WIDTH-1:0] rs2,
    output logic [2:0]       sel,
    input  logic [WIDTH-1:0] sal,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_mask,
    output logic [3:0]       err_count
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            sample;
    logic            mismatch;
    logic [3:0]      err_nxt;
    logic            accept;

    // Golden reference; shift amount uses only the low log2(WIDTH) bits of b.
    function automatic logic [WIDTH-1:0] golden(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0]          shamt;
        logic signed [WIDTH-1:0] a_s;
        shamt = b[SHW-1:0];
        a_s   = a;
        case (op)
            3'd0:    golden = a + b;
            3'd1:    golden = a - b;
            3'd2:    golden = a & b;
            3'd3:    golden = a | b;
            3'd4:    golden = a ^ b;
            3'd5:    golden = a << shamt;
            3'd6:    golden = a >> shamt;
            default: golden = a_s >>> shamt;
        endcase
    endfunction

    always_comb begin
        accept   = (state == IDLE) && start;
        sample   = (state == WAIT) && (cnt == '0);
        mismatch = sample && (sal != golden(sel, rs1, rs2));
        err_nxt  = err_count + {3'd0, mismatch};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WAIT;
            WAIT: if (sample && (sel == 3'd7)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode straight from the registered state
    always_comb begin
        busy = (state == WAIT);
        done = (state == DONE);
    end

    // Sweep datapath: operands, select, settle counter and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1       <= '0;
            rs2       <= '0;
            sel       <= 3'd0;
            cnt       <= '0;
            fail_mask <= 8'h00;
            err_count <= 4'd0;
            pass      <= 1'b0;
        end else if (accept) begin
            rs1       <= op_a;
            rs2       <= op_b;
            sel       <= 3'd0;
            cnt       <= CW'(SETTLE);
            fail_mask <= 8'h00;
            err_count <= 4'd0;
            pass      <= 1'b0;
        end else if (state == WAIT) begin
            if (!sample) begin
                cnt <= cnt - CW'(1);
            end else begin
                err_count <= err_nxt;
                if (mismatch) begin
                    fail_mask[sel] <= 1'b1;
                end
                // Last operation: pass must include this edge's comparison
                if (sel == 3'd7) begin
                    pass <= (err_nxt == 4'd0);
                end else begin
                    sel <= sel + 3'd1;
                    cnt <= CW'(SETTLE);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_selftest_checker.sv
// Bench for alu_selftest_checker: behavioural ALU with injectable faults beside
// a SETTLE=1 and a SETTLE=0 instance, scoreboard-driven directed sweeps.
module tb_alu_selftest_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    int          fault;
    bit          use1;

    logic [31:0] rs1_0, rs2_0, sal0, rs1_1, rs2_1, sal1;
    logic [2:0]  sel0, sel1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0]  mask0, mask1;
    logic [3:0]  err0, err1;
    logic        start0, start1;

    logic [31:0] rs1_m, rs2_m, sal_m;
    logic [2:0]  sel_m;
    logic        busy_m, done_m, pass_m;
    logic [7:0]  mask_m;
    logic [3:0]  err_m;

    int tests;
    int fails;

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sal_q[$];

    alu_selftest_checker #(.WIDTH(32), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b),
        .rs1(rs1_0), .rs2(rs2_0), .sel(sel0), .sal(sal0), .busy(busy0),
        .done(done0), .pass(pass0), .fail_mask(mask0), .err_count(err0)
    );

    alu_selftest_checker #(.WIDTH(32), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
        .rs1(rs1_1), .rs2(rs2_1), .sel(sel1), .sal(sal1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_mask(mask1), .err_count(err1)
    );

    // Behavioural ALU; fault 1 makes SUB return the sum, fault 2 makes SRA logical
    function automatic logic [31:0] alu(input logic [2:0] s, input logic [31:0] a,
                                        input logic [31:0] b, input int f);
        logic [4:0] sh;
        sh = b[4:0];
        case (s)
            3'd0:    return a + b;
            3'd1:    return (f == 1) ? a + b : a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return (f == 2) ? (a >> sh) : 32'($signed(a) >>> sh);
        endcase
    endfunction

    always_comb sal0 = alu(sel0, rs1_0, rs2_0, fault);
    always_comb sal1 = alu(sel1, rs1_1, rs2_1, fault);

    assign start0 = start & ~use1;
    assign start1 = start & use1;
    assign rs1_m  = use1 ? rs1_1 : rs1_0;
    assign rs2_m  = use1 ? rs2_1 : rs2_0;
    assign sel_m  = use1 ? sel1  : sel0;
    assign sal_m  = use1 ? sal1  : sal0;
    assign busy_m = use1 ? busy1 : busy0;
    assign done_m = use1 ? done1 : done0;
    assign pass_m = use1 ? pass1 : pass0;
    assign mask_m = use1 ? mask1 : mask0;
    assign err_m  = use1 ? err1  : err0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_sal8(input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3,
                             input logic [31:0] v4, input logic [31:0] v5,
                             input logic [31:0] v6, input logic [31:0] v7);
        sal_q.push_back(v0); sal_q.push_back(v1); sal_q.push_back(v2); sal_q.push_back(v3);
        sal_q.push_back(v4); sal_q.push_back(v5); sal_q.push_back(v6); sal_q.push_back(v7);
    endtask

    task automatic run_sweep(input logic [31:0] a, input logic [31:0] b, input bit churn,
                             input logic [7:0] emask, input logic [3:0] eerr, input logic epass);
        exp_t        e;
        int          cyc;
        int          st;
        int          last;
        bit          pulsed;
        st = use1 ? 0 : 1;
        @(posedge clk); #1;
        op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back('{mask: emask, err: eerr, pass: epass});
        @(posedge clk); #1;
        start  = 1'b0;
        cyc    = 1;
        last   = -1;
        pulsed = 1'b0;
        chk("latched_rs1", rs1_m, a);
        chk("latched_rs2", rs2_m, b);
        while (!done_m && cyc < 100) begin
            chk("busy_in_sweep", 32'(busy_m), 32'd1);
            chk("pass_low_in_sweep", 32'(pass_m), 32'd0);
            chk("sel_sequence", 32'(sel_m), 32'((cyc - 1) / (st + 1)));
            if (int'(sel_m) != last) begin
                last = int'(sel_m);
                if (sal_q.size() > 0) chk("sal_sampled", sal_m, sal_q.pop_front());
            end
            if (churn) begin
                op_a = ~op_a;
                if (sel_m == 3'd4 && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", 32'(cyc), 32'(8 * (st + 1) + 1));
        e = exp_q.pop_front();
        chk("done_asserted", 32'(done_m), 32'd1);
        chk("busy_in_done", 32'(busy_m), 32'd0);
        chk("pass", 32'(pass_m), 32'(e.pass));
        chk("fail_mask", 32'(mask_m), 32'(e.mask));
        chk("err_count", 32'(err_m), 32'(e.err));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_m), 32'd0);
        chk("pass_hold", 32'(pass_m), 32'(e.pass));
        chk("fail_mask_hold", 32'(mask_m), 32'(e.mask));
        chk("err_count_hold", 32'(err_m), 32'(e.err));
    endtask

    initial begin
        int n;
        bit saw_done;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        fault = 0;
        use1  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_pass", 32'(pass0), 32'd0);
        chk("rst_mask", 32'(mask0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_rs1", rs1_0, 32'd0);
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_busy_s0", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // Correct ALU
        push_sal8(32'd233, 32'd219, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd1);
        run_sweep(32'd226, 32'd7, 1'b0, 8'h00, 4'd0, 1'b1);

        // SUB returns ADD
        fault = 1;
        push_sal8(32'd233, 32'd233, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd1);
        run_sweep(32'd226, 32'd7, 1'b0, 8'h02, 4'd1, 1'b0);

        // Sign / shift-amount masking
        fault = 0;
        push_sal8(32'h8000_0021, 32'h7FFF_FFDF, 32'h0, 32'h8000_0021,
                  32'h8000_0021, 32'h0, 32'h4000_0000, 32'hC000_0000);
        run_sweep(32'h8000_0000, 32'd33, 1'b0, 8'h00, 4'd0, 1'b1);
        fault = 2;
        push_sal8(32'h8000_0021, 32'h7FFF_FFDF, 32'h0, 32'h8000_0021,
                  32'h8000_0021, 32'h0, 32'h4000_0000, 32'h4000_0000);
        run_sweep(32'h8000_0000, 32'd33, 1'b0, 8'h80, 4'd1, 1'b0);

        // Reset mid-sweep at sel=3
        fault = 0;
        @(posedge clk); #1;
        op_a = 32'd226; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        saw_done = 1'b0;
        while (sel0 != 3'd3 && n < 50) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
            n++;
        end
        chk("reach_sel3", 32'(sel0), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        chk("midrst_pass", 32'(pass0), 32'd0);
        chk("midrst_mask", 32'(mask0), 32'd0);
        chk("midrst_err", 32'(err0), 32'd0);
        chk("midrst_rs1", rs1_0, 32'd0);
        chk("midrst_rs2", rs2_0, 32'd0);
        chk("midrst_sel", 32'(sel0), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
        end
        chk("no_done_after_reset", 32'(saw_done), 32'd0);
        push_sal8(32'd233, 32'd219, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd1);
        run_sweep(32'd226, 32'd7, 1'b0, 8'h00, 4'd0, 1'b1);

        // Start during busy with operand churn
        push_sal8(32'd233, 32'd219, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd1);
        run_sweep(32'd226, 32'd7, 1'b1, 8'h00, 4'd0, 1'b1);
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
        end
        chk("single_done_pulse", 32'(saw_done), 32'd0);
        chk("idle_after_churn", 32'(busy0), 32'd0);
        push_sal8(32'd233, 32'd219, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd1);
        run_sweep(32'd226, 32'd7, 1'b0, 8'h00, 4'd0, 1'b1);

        // SETTLE=0 instance
        use1 = 1'b1;
        push_sal8(32'd8, 32'd2, 32'd1, 32'd7, 32'd6, 32'd40, 32'd0, 32'd0);
        run_sweep(32'd5, 32'd3, 1'b0, 8'h00, 4'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
